cordic_loop: RTL and testbench

- Iterative CORDIC rotation engine that sits directly downstream of the sin/cos controller.
- The controller pulses startLoop once the reduced angle is ready, then waits for doneLoop before its X/Y post-processing states.
- The block computes cos and sin of the loaded angle in fixed point using one shift-add micro-rotation per clock.

---
 rtl/cordic_pkg.sv | 22 ++
 rtl/cordic_loop_if.sv | 22 ++
 rtl/cordic_atan_rom.sv | 19 +
 rtl/cordic_loop.sv | 125 ++++++++++++
 tb/tb_cordic_loop.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_pkg.sv
// Shared Q2.14 CORDIC constants: format, gain preload, pi/2 bound, arctangent table, FSM states.
// Also used by the sin/cos controller and the range-reduction stage.
package cordic_pkg;

   localparam int unsigned CORDIC_WIDTH = 16;
   localparam int unsigned CORDIC_FRAC  = 14;
   localparam int          K_INIT_Q     = 9949;
   localparam int          PI_HALF_Q    = 25736;

   localparam int unsigned ATAN_LEN = 14;
   // atan(2^-i) in Q2.14 for i = 0..13
   localparam logic [15:0] ATAN_TABLE [ATAN_LEN] = '{
      16'd12868, 16'd7596, 16'd4014, 16'd2037, 16'd1023, 16'd512, 16'd256,
      16'd128,   16'd64,   16'd32,   16'd16,   16'd8,    16'd4,   16'd2
   };

   typedef enum logic [0:0] {
      IDLE,
      ITERATE
   } cordic_state_e;

endpackage

// File: rtl/cordic_loop_if.sv
// Controller <-> CORDIC loop handshake and result bus.
interface cordic_loop_if #(
   parameter int unsigned WIDTH = 16
);
   logic                    startLoop;
   logic signed [WIDTH-1:0] angle_in;
   logic signed [WIDTH-1:0] cos_out;
   logic signed [WIDTH-1:0] sin_out;
   logic                    doneLoop;
   logic                    busy;
   logic                    range_err;

   modport master (
      output startLoop, angle_in,
      input  cos_out, sin_out, doneLoop, busy, range_err
   );

   modport slave (
      input  startLoop, angle_in,
      output cos_out, sin_out, doneLoop, busy, range_err
   );
endinterface

// File: rtl/cordic_atan_rom.sv
// Combinational index -> atan(2^-i) lookup in Q2.14; zero past the end of the table.
module cordic_atan_rom
   import cordic_pkg::*;
#(
   parameter int unsigned WIDTH = CORDIC_WIDTH,
   parameter int unsigned IdxW  = 4
) (
   input  logic [IdxW-1:0]         idx_i,
   output logic signed [WIDTH-1:0] atan_o
);

   always_comb begin
      atan_o = '0;
      if (int'(idx_i) < int'(ATAN_LEN)) begin
         atan_o = $signed(WIDTH'(ATAN_TABLE[idx_i]));
      end
   end

endmodule

// File: rtl/cordic_loop.sv
// Iterative CORDIC rotation: one shift-add micro-rotation per clock, ITER cycles per job.
// Produces Q2.14 cos/sin of the loaded angle and flags angles beyond +/- pi/2.
module cordic_loop
   import cordic_pkg::*;
#(
   parameter int unsigned WIDTH  = CORDIC_WIDTH,
   parameter int unsigned ITER   = 14,
   parameter int          K_INIT = K_INIT_Q
) (
   input logic          clk,
   input logic          start_restart,
   cordic_loop_if.slave bus
);

   localparam int unsigned IdxW = $clog2(WIDTH);
   localparam logic signed [WIDTH-1:0] PiHalfPos = WIDTH'(PI_HALF_Q);
   localparam logic signed [WIDTH-1:0] PiHalfNeg = WIDTH'(-PI_HALF_Q);

   cordic_state_e           state_q, state_d;
   logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
   logic signed [WIDTH-1:0] cos_q, cos_d, sin_q, sin_d;
   logic [IdxW-1:0]         idx_q, idx_d;
   logic                    done_q, done_d, busy_q, busy_d;
   logic                    rerr_q, rerr_d, rflag_q, rflag_d;

   logic signed [WIDTH-1:0] atan_val, x_sh, y_sh, x_rot, y_rot, z_rot;
   logic                    out_of_range;

   cordic_atan_rom #(
      .WIDTH (WIDTH),
      .IdxW  (IdxW)
   ) u_atan_rom (
      .idx_i  (idx_q),
      .atan_o (atan_val)
   );

   // Rotation direction follows the sign of the residual angle (d = -1 when z < 0).
   always_comb begin
      x_sh  = x_q >>> idx_q;
      y_sh  = y_q >>> idx_q;
      x_rot = z_q[WIDTH-1] ? (x_q + y_sh) : (x_q - y_sh);
      y_rot = z_q[WIDTH-1] ? (y_q - x_sh) : (y_q + x_sh);
      z_rot = z_q[WIDTH-1] ? (z_q + atan_val) : (z_q - atan_val);
      out_of_range = (bus.angle_in > PiHalfPos) || (bus.angle_in < PiHalfNeg);
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      idx_d   = idx_q;
      cos_d   = cos_q;
      sin_d   = sin_q;
      done_d  = 1'b0;
      busy_d  = busy_q;
      rerr_d  = rerr_q;
      rflag_d = rflag_q;
      unique case (state_q)
         IDLE: begin
            if (bus.startLoop) begin
               x_d     = WIDTH'(K_INIT);
               y_d     = '0;
               z_d     = bus.angle_in;
               idx_d   = '0;
               busy_d  = 1'b1;
               rerr_d  = 1'b0;
               rflag_d = out_of_range;
               state_d = ITERATE;
            end
         end
         ITERATE: begin
            x_d   = x_rot;
            y_d   = y_rot;
            z_d   = z_rot;
            idx_d = idx_q + 1'b1;
            if (idx_q == IdxW'(ITER - 1)) begin
               cos_d   = x_rot;
               sin_d   = y_rot;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               rerr_d  = rflag_q;
               idx_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (start_restart) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         idx_q   <= '0;
         cos_q   <= '0;
         sin_q   <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         rerr_q  <= 1'b0;
         rflag_q <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         idx_q   <= idx_d;
         cos_q   <= cos_d;
         sin_q   <= sin_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         rerr_q  <= rerr_d;
         rflag_q <= rflag_d;
      end
   end

   assign bus.cos_out   = cos_q;
   assign bus.sin_out   = sin_q;
   assign bus.doneLoop  = done_q;
   assign bus.busy      = busy_q;
   assign bus.range_err = rerr_q;

endmodule

// File: tb/tb_cordic_loop.sv
// Directed bench for cordic_loop: latency, accuracy (+/-16 LSB), range flag, busy-ignore, reset.
module tb_cordic_loop;
   import cordic_pkg::*;

   localparam int Tol = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   fails  = 0;

   always #5 clk = ~clk;

   cordic_loop_if #(.WIDTH(16)) bus ();

   cordic_loop dut (
      .clk           (clk),
      .start_restart (rst),
      .bus           (bus)
   );

   function automatic int adiff(input logic signed [15:0] a, input int b);
      return (int'(a) > b) ? (int'(a) - b) : (b - int'(a));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse startLoop for one edge and count edges until doneLoop (bounded).
   task automatic run_job(input int angle, output int lat);
      bus.angle_in  = 16'(angle);
      bus.startLoop = 1'b1;
      tick();
      bus.startLoop = 1'b0;
      lat = 0;
      while (!bus.doneLoop && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      bus.startLoop = 1'b0;
      bus.angle_in  = '0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if (bus.cos_out !== 16'sd0 || bus.sin_out !== 16'sd0 || bus.doneLoop !== 1'b0 ||
          bus.busy !== 1'b0 || bus.range_err !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: cos=%0d sin=%0d done=%b busy=%b rerr=%b, want all 0",
                  bus.cos_out, bus.sin_out, bus.doneLoop, bus.busy, bus.range_err);
      end
   endtask

   task automatic test_zero_angle();
      int lat;
      run_job(0, lat);
      checks++;
      if (lat !== 14) begin
         fails++;
         $display("FAIL zero_latency: got %0d cycles, want 14", lat);
      end
      checks++;
      if (adiff(bus.cos_out, 16384) > Tol || adiff(bus.sin_out, 0) > Tol) begin
         fails++;
         $display("FAIL zero_result: cos=%0d sin=%0d, want 16384/0 +/-16",
                  bus.cos_out, bus.sin_out);
      end
      checks++;
      if (bus.range_err !== 1'b0) begin
         fails++;
         $display("FAIL zero_range_err: got %b, want 0", bus.range_err);
      end
      tick();
      checks++;
      if (bus.doneLoop !== 1'b0) begin
         fails++;
         $display("FAIL done_pulse_width: doneLoop=%b one cycle later, want 0", bus.doneLoop);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      run_job(8579, lat);
      checks++;
      if (lat !== 14 || adiff(bus.cos_out, 14189) > Tol || adiff(bus.sin_out, 8192) > Tol) begin
         fails++;
         $display("FAIL pi6_result: lat=%0d cos=%0d sin=%0d, want 14 14189 8192",
                  lat, bus.cos_out, bus.sin_out);
      end
      // Issue the next job while doneLoop is still high.
      bus.angle_in  = -16'sd12868;
      bus.startLoop = 1'b1;
      tick();
      bus.startLoop = 1'b0;
      checks++;
      if (bus.busy !== 1'b1 || bus.doneLoop !== 1'b0 || adiff(bus.cos_out, 14189) > Tol) begin
         fails++;
         $display("FAIL b2b_accept: busy=%b done=%b cos=%0d, want 1 0 held 14189",
                  bus.busy, bus.doneLoop, bus.cos_out);
      end
      lat = 0;
      while (!bus.doneLoop && lat < 40) begin
         tick();
         lat++;
      end
      checks++;
      if (lat !== 14 || adiff(bus.cos_out, 11585) > Tol || adiff(bus.sin_out, -11585) > Tol) begin
         fails++;
         $display("FAIL mpi4_result: lat=%0d cos=%0d sin=%0d, want 14 11585 -11585",
                  lat, bus.cos_out, bus.sin_out);
      end
      tick();
   endtask

   task automatic test_range();
      int lat;
      run_job(25736, lat);
      checks++;
      if (lat !== 14 || adiff(bus.cos_out, 0) > Tol || adiff(bus.sin_out, 16384) > Tol ||
          bus.range_err !== 1'b0) begin
         fails++;
         $display("FAIL pi2_result: lat=%0d cos=%0d sin=%0d rerr=%b, want 14 0 16384 0",
                  lat, bus.cos_out, bus.sin_out, bus.range_err);
      end
      tick();
      run_job(30000, lat);
      checks++;
      if (lat !== 14 || bus.range_err !== 1'b1) begin
         fails++;
         $display("FAIL oor_flag: lat=%0d rerr=%b, want 14 1", lat, bus.range_err);
      end
      tick();
      checks++;
      if (bus.range_err !== 1'b1) begin
         fails++;
         $display("FAIL oor_hold: rerr=%b while idle, want 1", bus.range_err);
      end
      bus.angle_in  = -16'sd25737;
      bus.startLoop = 1'b1;
      tick();
      bus.startLoop = 1'b0;
      checks++;
      if (bus.range_err !== 1'b0) begin
         fails++;
         $display("FAIL oor_clear_on_accept: rerr=%b, want 0", bus.range_err);
      end
      lat = 0;
      while (!bus.doneLoop && lat < 40) begin
         tick();
         lat++;
      end
      checks++;
      if (lat !== 14 || bus.range_err !== 1'b1) begin
         fails++;
         $display("FAIL oor_negative: lat=%0d rerr=%b, want 14 1", lat, bus.range_err);
      end
      tick();
   endtask

   task automatic test_ignore_busy();
      int done_cnt = 0;
      int done_at  = -1;
      bit busy_gap = 1'b0;
      bus.angle_in  = 16'sd8579;
      bus.startLoop = 1'b1;
      tick();
      bus.startLoop = 1'b0;
      if (bus.busy !== 1'b1) busy_gap = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         if (c == 5) begin
            bus.angle_in  = 16'sd12868;
            bus.startLoop = 1'b1;
         end
         tick();
         bus.startLoop = 1'b0;
         if (bus.doneLoop) begin
            done_cnt++;
            if (done_at < 0) done_at = c;
         end
         if (c <= 13 && bus.busy !== 1'b1) busy_gap = 1'b1;
      end
      checks++;
      if (done_cnt !== 1 || done_at !== 14) begin
         fails++;
         $display("FAIL busy_ignore_done: count=%0d at=%0d, want 1 at 14", done_cnt, done_at);
      end
      checks++;
      if (busy_gap !== 1'b0) begin
         fails++;
         $display("FAIL busy_continuous: gap=%b, want 0", busy_gap);
      end
      checks++;
      if (adiff(bus.cos_out, 14189) > Tol || adiff(bus.sin_out, 8192) > Tol) begin
         fails++;
         $display("FAIL busy_ignore_result: cos=%0d sin=%0d, want 14189 8192",
                  bus.cos_out, bus.sin_out);
      end
   endtask

   task automatic test_restart_mid_job();
      int  lat;
      bit  saw_done = 1'b0;
      bus.angle_in  = 16'sd30000;
      bus.startLoop = 1'b1;
      tick();
      bus.startLoop = 1'b0;
      for (int c = 1; c <= 6; c++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (bus.cos_out !== 16'sd0 || bus.sin_out !== 16'sd0 || bus.doneLoop !== 1'b0 ||
          bus.busy !== 1'b0 || bus.range_err !== 1'b0) begin
         fails++;
         $display("FAIL restart_clear: cos=%0d sin=%0d done=%b busy=%b rerr=%b, want all 0",
                  bus.cos_out, bus.sin_out, bus.doneLoop, bus.busy, bus.range_err);
      end
      for (int c = 0; c < 25; c++) begin
         tick();
         if (bus.doneLoop) saw_done = 1'b1;
      end
      checks++;
      if (saw_done !== 1'b0) begin
         fails++;
         $display("FAIL restart_no_done: doneLoop seen=%b, want 0", saw_done);
      end
      run_job(0, lat);
      checks++;
      if (lat !== 14 || adiff(bus.cos_out, 16384) > Tol || adiff(bus.sin_out, 0) > Tol) begin
         fails++;
         $display("FAIL restart_fresh_job: lat=%0d cos=%0d sin=%0d, want 14 16384 0",
                  lat, bus.cos_out, bus.sin_out);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_zero_angle();
      test_back_to_back();
      test_range();
      test_ignore_busy();
      test_restart_mid_job();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
